truth_table_sweeper: RTL and testbench

- Sequential stimulus-and-capture stage that wraps a 3-input combinational logic gate, for example the 0x82 rule gate.
- Drives in1/in2/in3 through all 8 input combinations.
- Holds each combination for a programmable settle time, then samples the gate's `out`.
- Assembles the observed 8-bit truth table and compares it with an expected rule code.
- Sits directly upstream of the gate (feeds its inputs) and also consumes its output.

---
 rtl/truth_table_sweeper.sv | 142 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input gate through all eight input vectors, samples its synchronised output
// after a programmable settle time and compares the observed truth table against a rule code.
module truth_table_sweeper #(
    parameter logic [7:0] EXPECTED      = 8'h82,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       gate_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match,
    output logic [7:0] mismatch_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [2:0]       idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]       table_reg, table_next;
    logic             match_reg, match_next;
    logic [7:0]       mask_reg, mask_next;
    logic             sync1_reg, gate_s_reg;
    logic             accept;
    logic             sample_en;

    assign accept    = (state_reg == IDLE) && start;
    assign sample_en = (state_reg == SAMPLE);

    // gate_out is unrelated to clk, so only the second flop is ever looked at
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg  <= 1'b0;
            gate_s_reg <= 1'b0;
        end else begin
            sync1_reg  <= gate_out;
            gate_s_reg <= sync1_reg;
        end
    end

    // Each table bit owns one vector: bit [7-idx] is written only while that idx is sampled
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slot
            localparam logic [2:0] SLOT_IDX = 3'(7 - gi);
            always_comb begin
                table_next[gi] = table_reg[gi];
                if (accept) begin
                    table_next[gi] = 1'b0;
                end else if (sample_en && (idx_reg == SLOT_IDX)) begin
                    table_next[gi] = gate_s_reg;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        match_next = match_reg;
        mask_next  = mask_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SETTLE;
                    idx_next   = 3'd0;
                    cnt_next   = RELOAD;
                    match_next = 1'b0;
                    mask_next  = 8'h00;
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (idx_reg == 3'd7) begin
                    // Compare against the table including this final bit so the verdict is ready in DONE
                    state_next = DONE;
                    match_next = (table_next == EXPECTED);
                    mask_next  = table_next ^ EXPECTED;
                end else begin
                    state_next = SETTLE;
                    idx_next   = idx_reg + 3'd1;
                    cnt_next   = RELOAD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            cnt_reg   <= '0;
            table_reg <= 8'h00;
            match_reg <= 1'b0;
            mask_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            table_reg <= table_next;
            match_reg <= match_next;
            mask_reg  <= mask_next;
        end
    end

    // The vector index doubles as the gate drive; it rests at 111 after a sweep
    assign in1           = idx_reg[2];
    assign in2           = idx_reg[1];
    assign in3           = idx_reg[0];
    assign busy          = (state_reg == SETTLE) || (state_reg == SAMPLE);
    assign done          = (state_reg == DONE);
    assign table_out     = table_reg;
    assign match         = match_reg;
    assign mismatch_mask = mask_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (default settle time with an ideal gate, short settle time
// with a lagging gate) checked cycle by cycle against a timing and truth-table reference model.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b;
    logic [7:0] tt_a, tt_b;   // gate truth tables, bit i = output for input vector i
    logic       in1_a, in2_a, in3_a, busy_a, done_a, match_a, gate_out_a;
    logic       in1_b, in2_b, in3_b, busy_b, done_b, match_b, gate_out_b;
    logic [7:0] table_a, mask_a, table_b, mask_b;
    logic [2:0] lag_b = 3'b000;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] TT_82 = 8'h41;  // out=1 only for inputs 000 and 110

    // Ideal combinational gate for A; B's gate answers one clock after its inputs move
    assign gate_out_a = tt_a[{in1_a, in2_a, in3_a}];
    always_ff @(posedge clk) lag_b <= {in1_b, in2_b, in3_b};
    assign gate_out_b = tt_b[lag_b];

    truth_table_sweeper #(.EXPECTED(8'h82), .SETTLE_CYCLES(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .in1(in1_a), .in2(in2_a), .in3(in3_a), .gate_out(gate_out_a),
        .busy(busy_a), .done(done_a), .table_out(table_a), .match(match_a),
        .mismatch_mask(mask_a)
    );

    truth_table_sweeper #(.EXPECTED(8'h82), .SETTLE_CYCLES(3), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .in1(in1_b), .in2(in2_b), .in3(in3_b), .gate_out(gate_out_b),
        .busy(busy_b), .done(done_b), .table_out(table_b), .match(match_b),
        .mismatch_mask(mask_b)
    );

    logic       sel;
    logic [2:0] o_vec;
    logic       o_busy, o_done, o_match;
    logic [7:0] o_table, o_mask;

    always_comb begin
        if (sel) begin
            o_vec = {in1_b, in2_b, in3_b}; o_busy = busy_b; o_done = done_b;
            o_match = match_b; o_table = table_b; o_mask = mask_b;
        end else begin
            o_vec = {in1_a, in2_a, in3_a}; o_busy = busy_a; o_done = done_a;
            o_match = match_a; o_table = table_a; o_mask = mask_a;
        end
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Reference: the sweep records the gate's answer to vector i at table bit 7-i
    function automatic logic [7:0] model_table(input logic [7:0] tt);
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < 8; i++) t[7-i] = tt[i];
        return t;
    endfunction

    // Called at a falling edge; start is taken at the following rising edge (T)
    task automatic sweep(input bit use_b, input int sc, input logic [7:0] tt, input bit hold,
                         input logic [7:0] exp_tab, input logic exp_match,
                         input logic [7:0] exp_mask);
        int span;
        span = 8 * (sc + 1);
        sel  = use_b;
        if (use_b) begin tt_b = tt; start_b = 1'b1; end
        else       begin tt_a = tt; start_a = 1'b1; end
        @(posedge clk); #1;
        if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
        for (int k = 1; k <= span; k++) begin
            @(negedge clk);
            check1("busy", o_busy, 1'b1);
            check1("done_early", o_done, 1'b0);
            check8("vector", {5'd0, o_vec}, 8'((k - 1) / (sc + 1)));
            if (k == 1) begin
                check8("clear_table", o_table, 8'h00);
                check1("clear_match", o_match, 1'b0);
                check8("clear_mask", o_mask, 8'h00);
            end
        end
        @(negedge clk);
        check1("done", o_done, 1'b1);
        check1("busy_in_done", o_busy, 1'b0);
        check8("table", o_table, exp_tab);
        check1("match", o_match, exp_match);
        check8("mask", o_mask, exp_mask);
        $display("sweep dut=%s gate_tt=%02h table=%02h match=%0b mask=%02h",
                 use_b ? "b" : "a", tt, o_table, o_match, o_mask);
        @(negedge clk);
        check1("done_pulse_width", o_done, 1'b0);
        check8("rest_vector", {5'd0, o_vec}, 8'h07);
    endtask

    initial begin
        logic [7:0] tt, exp_t, prev_t;
        int gap, dones;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        tt_a = 8'h00; tt_b = 8'h00; sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = (d == 1); #1;
            check8("rst_vector", {5'd0, o_vec}, 8'h00);
            check1("rst_busy", o_busy, 1'b0);
            check1("rst_done", o_done, 1'b0);
            check8("rst_table", o_table, 8'h00);
            check1("rst_match", o_match, 1'b0);
            check8("rst_mask", o_mask, 8'h00);
        end
        $display("reset checked on both instances");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sweeps on the default instance
        sweep(1'b0, 16, TT_82, 1'b0, 8'h82, 1'b1, 8'h00);
        sweep(1'b0, 16, 8'h00, 1'b0, 8'h00, 1'b0, 8'h82);
        sweep(1'b0, 16, 8'hFF, 1'b0, 8'hFF, 1'b0, 8'h7D);
        sweep(1'b0, 16, 8'h49, 1'b0, 8'h92, 1'b0, 8'h10);

        // start held high: no requeue mid-sweep, next sweep from the first idle cycle
        sweep(1'b0, 16, TT_82, 1'b1, 8'h82, 1'b1, 8'h00);
        sweep(1'b0, 16, TT_82, 1'b0, 8'h82, 1'b1, 8'h00);

        // Short settle time with a lagging gate
        sweep(1'b1, 3, TT_82, 1'b0, 8'h82, 1'b1, 8'h00);

        // Random gates with idle gaps; results must hold while idle
        prev_t = 8'h82;
        for (int r = 0; r < 7; r++) begin
            sel = (r >= 4);
            if (r == 4) prev_t = 8'h82;
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check1("idle_busy", o_busy, 1'b0);
                check8("idle_hold_table", o_table, prev_t);
                check8("idle_hold_mask", o_mask, prev_t ^ 8'h82);
            end
            tt    = 8'($urandom);
            exp_t = model_table(tt);
            sweep(r >= 4, (r >= 4) ? 3 : 16, tt, 1'b0, exp_t, exp_t == 8'h82, exp_t ^ 8'h82);
            prev_t = exp_t;
        end

        // Reset during SETTLE of vector 4 discards the sweep
        sel = 1'b0; tt_a = TT_82; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (4 * 17 + 5) @(negedge clk);
        check8("pre_reset_vector", {5'd0, o_vec}, 8'h04);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check8("midrst_vector", {5'd0, o_vec}, 8'h00);
        check1("midrst_busy", o_busy, 1'b0);
        check8("midrst_table", o_table, 8'h00);
        check1("midrst_match", o_match, 1'b0);
        dones = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (o_done) dones++;
        end
        check8("midrst_no_done", 8'(dones), 8'h00);
        check1("midrst_idle", o_busy, 1'b0);
        $display("mid-sweep reset done_pulses=%0d", dones);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
